// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state/port encodings and helpers for the external bus arbiter
package bus_arbiter_pkg;

  // Access sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } bus_state_e;

  // Requesting master identity
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } bus_port_e;

  // Request fields latched at grant time and held for the whole access
  typedef struct packed {
    logic        wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bus_req_t;

  localparam logic [15:0] BUS_WORD_RESET = 16'h0000;
  localparam int unsigned MAX_WAIT_STATES = 15;

  // Active-low byte write strobes {wrn1, wrn0}; a read never asserts them
  function automatic logic [1:0] write_strobes_n(input logic wr, input logic [1:0] be);
    return ~({2{wr}} & be);
  endfunction

endpackage

// File: rtl/bus_strobe_timer.sv
// rtl/bus_strobe_timer.sv - 4-bit loadable down-counter timing the STROBE phase
module bus_strobe_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       done
);

  logic [3:0] count;

  // Load on request, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master external 16-bit bus arbiter/sequencer; optional BUS_ARB_ROUND_ROBIN_EN
module bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        A_REQ,
  input  logic        A_WR,
  input  logic [1:0]  A_BE,
  input  logic [15:0] A_ADDR,
  input  logic [15:0] A_WDATA,
  output logic        A_ACK,
  input  logic        B_REQ,
  input  logic        B_WR,
  input  logic [1:0]  B_BE,
  input  logic [15:0] B_ADDR,
  input  logic [15:0] B_WDATA,
  output logic        B_ACK,
  output logic [15:0] RDATA,
  output logic        B_OWNER,
  input  logic [15:0] DIN,
  output logic [15:0] ADDR_BUF,
  output logic [15:0] DOUT_BUF,
  output logic        RDN_BUF,
  output logic        WRN0_BUF,
  output logic        WRN1_BUF,
  output logic        ABUS_OEN,
  output logic        DBUS_OEN
);

  import bus_arbiter_pkg::*;

  localparam logic [3:0] STROBE_LOAD = 4'(WAIT_STATES);

  bus_state_e  state, state_nxt;
  bus_port_e   owner, owner_nxt;
  bus_port_e   winner;
  bus_req_t    lat, lat_nxt;
  bus_req_t    winner_req;

  logic [15:0] addr_nxt;
  logic [15:0] dout_nxt;
  logic [15:0] rdata_nxt;
  logic        rdn_nxt;
  logic [1:0]  wrn_nxt;
  logic        abus_oen_nxt;
  logic        dbus_oen_nxt;
  logic        b_owner_nxt;
  logic        a_ack_nxt;
  logic        b_ack_nxt;
  logic        timer_load;
  logic        timer_done;

  bus_strobe_timer u_timer (
    .clk        (CLK),
    .rst_n      (RESETN),
    .load       (timer_load),
    .load_value (STROBE_LOAD),
    .done       (timer_done)
  );

`ifdef BUS_ARB_ROUND_ROBIN_EN
  bus_port_e last_grant;

  // Tie goes to the port not granted last; a lone request always wins
  always_comb begin
    winner = PORT_A;
    if (A_REQ && B_REQ) begin
      winner = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (B_REQ) begin
      winner = PORT_B;
    end
  end

  // Remember who got the bus at each grant
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      last_grant <= PORT_A;
    end else if (state == ST_IDLE && (A_REQ || B_REQ)) begin
      last_grant <= winner;
    end
  end
`else
  // Fixed priority: the core never waits behind the DMA
  always_comb begin
    winner = PORT_A;
    if (!A_REQ && B_REQ) begin
      winner = PORT_B;
    end
  end
`endif

  // Request fields of whichever port wins this cycle
  always_comb begin
    winner_req = '0;
    if (winner == PORT_B) begin
      winner_req.wr    = B_WR;
      winner_req.be    = B_BE;
      winner_req.addr  = B_ADDR;
      winner_req.wdata = B_WDATA;
    end else begin
      winner_req.wr    = A_WR;
      winner_req.be    = A_BE;
      winner_req.addr  = A_ADDR;
      winner_req.wdata = A_WDATA;
    end
  end

  // Next state and next value of every registered output
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    lat_nxt      = lat;
    addr_nxt     = ADDR_BUF;
    dout_nxt     = DOUT_BUF;
    rdata_nxt    = RDATA;
    rdn_nxt      = 1'b1;
    wrn_nxt      = 2'b11;
    abus_oen_nxt = ABUS_OEN;
    dbus_oen_nxt = DBUS_OEN;
    b_owner_nxt  = B_OWNER;
    a_ack_nxt    = 1'b0;
    b_ack_nxt    = 1'b0;
    timer_load   = 1'b0;

    case (state)
      ST_IDLE: begin
        abus_oen_nxt = 1'b1;
        dbus_oen_nxt = 1'b1;
        b_owner_nxt  = 1'b0;
        if (A_REQ || B_REQ) begin
          state_nxt    = ST_SETUP;
          owner_nxt    = winner;
          lat_nxt      = winner_req;
          abus_oen_nxt = 1'b0;
          addr_nxt     = winner_req.addr;
          dbus_oen_nxt = ~winner_req.wr;
          if (winner_req.wr) begin
            dout_nxt = winner_req.wdata;
          end
          b_owner_nxt  = (winner == PORT_B);
        end
      end

      ST_SETUP: begin
        state_nxt  = ST_STROBE;
        timer_load = 1'b1;
        rdn_nxt    = lat.wr;
        wrn_nxt    = write_strobes_n(lat.wr, lat.be);
      end

      ST_STROBE: begin
        if (timer_done) begin
          state_nxt = ST_HOLD;
          if (!lat.wr) begin
            rdata_nxt = DIN;
          end
          a_ack_nxt = (owner == PORT_A);
          b_ack_nxt = (owner == PORT_B);
        end else begin
          rdn_nxt = lat.wr;
          wrn_nxt = write_strobes_n(lat.wr, lat.be);
        end
      end

      ST_HOLD: begin
        state_nxt    = ST_IDLE;
        abus_oen_nxt = 1'b1;
        dbus_oen_nxt = 1'b1;
        b_owner_nxt  = 1'b0;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered pad/handshake outputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= ST_IDLE;
      owner    <= PORT_A;
      lat      <= '0;
      ADDR_BUF <= BUS_WORD_RESET;
      DOUT_BUF <= BUS_WORD_RESET;
      RDATA    <= BUS_WORD_RESET;
      RDN_BUF  <= 1'b1;
      WRN0_BUF <= 1'b1;
      WRN1_BUF <= 1'b1;
      ABUS_OEN <= 1'b1;
      DBUS_OEN <= 1'b1;
      B_OWNER  <= 1'b0;
      A_ACK    <= 1'b0;
      B_ACK    <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lat      <= lat_nxt;
      ADDR_BUF <= addr_nxt;
      DOUT_BUF <= dout_nxt;
      RDATA    <= rdata_nxt;
      RDN_BUF  <= rdn_nxt;
      WRN0_BUF <= wrn_nxt[0];
      WRN1_BUF <= wrn_nxt[1];
      ABUS_OEN <= abus_oen_nxt;
      DBUS_OEN <= dbus_oen_nxt;
      B_OWNER  <= b_owner_nxt;
      A_ACK    <= a_ack_nxt;
      B_ACK    <= b_ack_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed table-driven bench for bus_arbiter (WAIT_STATES 0 and 2 instances)
`timescale 1ns/1ps
module tb_bus_arbiter;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESETN;
  logic        a_req, b_req, a_req2, b_req2;
  logic        a_wr, b_wr;
  logic [1:0]  a_be, b_be;
  logic [15:0] a_addr, b_addr, a_wdata, b_wdata, din;

  logic        a_ack0, b_ack0, b_owner0, rdn0, wrn0_0, wrn1_0, aoen0, doen0;
  logic [15:0] rdata0, addr0, dout0;
  logic        a_ack2, b_ack2, b_owner2, rdn2, wrn0_2, wrn1_2, aoen2, doen2;
  logic [15:0] rdata2, addr2, dout2;

  bus_arbiter #(.WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RESETN(RESETN),
    .A_REQ(a_req), .A_WR(a_wr), .A_BE(a_be), .A_ADDR(a_addr), .A_WDATA(a_wdata), .A_ACK(a_ack0),
    .B_REQ(b_req), .B_WR(b_wr), .B_BE(b_be), .B_ADDR(b_addr), .B_WDATA(b_wdata), .B_ACK(b_ack0),
    .RDATA(rdata0), .B_OWNER(b_owner0), .DIN(din), .ADDR_BUF(addr0), .DOUT_BUF(dout0),
    .RDN_BUF(rdn0), .WRN0_BUF(wrn0_0), .WRN1_BUF(wrn1_0), .ABUS_OEN(aoen0), .DBUS_OEN(doen0)
  );

  bus_arbiter #(.WAIT_STATES(2)) dut2 (
    .CLK(CLK), .RESETN(RESETN),
    .A_REQ(a_req2), .A_WR(a_wr), .A_BE(a_be), .A_ADDR(a_addr), .A_WDATA(a_wdata), .A_ACK(a_ack2),
    .B_REQ(b_req2), .B_WR(b_wr), .B_BE(b_be), .B_ADDR(b_addr), .B_WDATA(b_wdata), .B_ACK(b_ack2),
    .RDATA(rdata2), .B_OWNER(b_owner2), .DIN(din), .ADDR_BUF(addr2), .DOUT_BUF(dout2),
    .RDN_BUF(rdn2), .WRN0_BUF(wrn0_2), .WRN1_BUF(wrn1_2), .ABUS_OEN(aoen2), .DBUS_OEN(doen2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic        drop;
    int          exp_rd;
    int          exp_w0;
    int          exp_w1;
    int          exp_doen;
    int          exp_bown;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          ack_cyc;
    int          acks;
    int          other;
    int          rd;
    int          w0;
    int          w1;
    int          doen;
    int          aoen;
    int          bown;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] rdata;
  } res_t;

  // One access on the WAIT_STATES=0 instance, observed for 7 cycles after the grant edge
  task automatic do_access(input vec_t v, output res_t r);
    logic own, oth;
    r.ack_cyc = 0; r.acks = 0; r.other = 0; r.rd = 0; r.w0 = 0; r.w1 = 0;
    r.doen = 0; r.aoen = 0; r.bown = 0; r.addr = 16'h0; r.dout = 16'h0; r.rdata = 16'h0;
    din = v.din;
    if (v.port == 1'b0) begin
      a_wr = v.wr; a_be = v.be; a_addr = v.addr; a_wdata = v.wdata; a_req = 1'b1;
    end else begin
      b_wr = v.wr; b_be = v.be; b_addr = v.addr; b_wdata = v.wdata; b_req = 1'b1;
    end
    for (int k = 1; k <= 7; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (!rdn0)   r.rd++;
      if (!wrn0_0) r.w0++;
      if (!wrn1_0) r.w1++;
      if (!doen0) begin r.doen++; r.dout = dout0; end
      if (!aoen0) begin r.aoen++; r.addr = addr0; end
      if (b_owner0) r.bown++;
      own = v.port ? b_ack0 : a_ack0;
      oth = v.port ? a_ack0 : b_ack0;
      if (oth) r.other++;
      if (own) begin
        r.acks++;
        if (r.ack_cyc == 0) r.ack_cyc = k;
        r.rdata = rdata0;
        a_req = 1'b0; b_req = 1'b0;
      end
      if (k == 1 && v.drop) begin a_req = 1'b0; b_req = 1'b0; end
    end
  endtask

  // Simultaneous A and B reads on the WAIT_STATES=0 instance
  task automatic do_tie(output int a_cyc, output int b_cyc);
    a_cyc = 0; b_cyc = 0;
    a_wr = 1'b0; b_wr = 1'b0; a_addr = 16'h0A0A; b_addr = 16'h0B0B; din = 16'h7777;
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (a_ack0 && a_cyc == 0) begin a_cyc = k; a_req = 1'b0; end
      if (b_ack0 && b_cyc == 0) begin b_cyc = k; b_req = 1'b0; end
    end
  endtask

  vec_t vecs[6];
  vec_t bvec;
  res_t r;
  logic last_port;
  logic first_port;
  int   a_cyc, b_cyc;
  int   ack_cyc, w0c, w1c, rdc, doen_ok, aoen_ok, bown_c, oth_c, acks, aoen_first;
  int   high_run, gap, rd_low, n_ack, ack1, ack2;
  logic seen_low;
  logic [15:0] rd1, rd2, saddr1, saddr2, cap_rdata;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 2'b00, 16'h1234, 16'h0000, 16'hBEEF, 1'b0, 1, 0, 0, 0, 0, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 2'b11, 16'h0200, 16'hA5A5, 16'h0000, 1'b0, 0, 1, 1, 3, 0, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 2'b00, 16'h0300, 16'h3C3C, 16'h0000, 1'b0, 0, 0, 0, 3, 3, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 16'h4444, 16'h0000, 16'h1357, 1'b0, 1, 0, 0, 0, 3, 16'h1357};
    vecs[4] = '{1'b0, 1'b1, 2'b10, 16'h0500, 16'hF00D, 16'h0000, 1'b1, 0, 0, 1, 3, 0, 16'h1357};
    vecs[5] = '{1'b0, 1'b0, 2'b00, 16'h0600, 16'h0000, 16'h0F0F, 1'b1, 1, 0, 0, 0, 0, 16'h0F0F};

    RESETN = 1'b0;
    a_req = 0; b_req = 0; a_req2 = 0; b_req2 = 0;
    a_wr = 0; b_wr = 0; a_be = 0; b_be = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0; din = 0;
    last_port = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_strobes", {rdn0, wrn0_0, wrn1_0, aoen0, doen0}, 5'b11111);
    check("rst_acks", {a_ack0, b_ack0, b_owner0}, 3'b000);
    check("rst_addr", addr0, 16'h0000);
    check("rst_dout", dout0, 16'h0000);
    check("rst_rdata", rdata0, 16'h0000);
    RESETN = 1'b1;
    @(posedge CLK); @(negedge CLK);

    // Single accesses on the zero-wait-state instance
    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i], r);
      check($sformatf("v%0d_ack_cyc", i), r.ack_cyc, 3);
      check($sformatf("v%0d_ack_pulses", i), r.acks, 1);
      check($sformatf("v%0d_other_ack", i), r.other, 0);
      check($sformatf("v%0d_rdn_low", i), r.rd, vecs[i].exp_rd);
      check($sformatf("v%0d_wrn0_low", i), r.w0, vecs[i].exp_w0);
      check($sformatf("v%0d_wrn1_low", i), r.w1, vecs[i].exp_w1);
      check($sformatf("v%0d_dbus_oen_low", i), r.doen, vecs[i].exp_doen);
      check($sformatf("v%0d_abus_oen_low", i), r.aoen, 3);
      check($sformatf("v%0d_b_owner", i), r.bown, vecs[i].exp_bown);
      check($sformatf("v%0d_addr", i), r.addr, vecs[i].addr);
      check($sformatf("v%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
      if (vecs[i].wr) check($sformatf("v%0d_dout", i), r.dout, vecs[i].wdata);
      last_port = vecs[i].port;
    end

    // Tie, lone B write, tie again
`ifdef BUS_ARB_ROUND_ROBIN_EN
    first_port = ~last_port;
`else
    first_port = 1'b0;
`endif
    do_tie(a_cyc, b_cyc);
    check("tie1_a_ack_cyc", a_cyc, first_port ? 7 : 3);
    check("tie1_b_ack_cyc", b_cyc, first_port ? 3 : 7);
    last_port = ~first_port;

    bvec = '{1'b1, 1'b1, 2'b11, 16'h0800, 16'h1111, 16'h0000, 1'b0, 0, 1, 1, 3, 3, 16'h7777};
    do_access(bvec, r);
    check("bonly_ack_cyc", r.ack_cyc, 3);
    check("bonly_b_owner", r.bown, 3);
    last_port = 1'b1;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    first_port = ~last_port;
`else
    first_port = 1'b0;
`endif
    do_tie(a_cyc, b_cyc);
    check("tie2_a_ack_cyc", a_cyc, first_port ? 7 : 3);
    check("tie2_b_ack_cyc", b_cyc, first_port ? 3 : 7);

    // Write with two wait states; A_ADDR/A_WDATA change mid-access and must be ignored
    a_wr = 1'b1; a_be = 2'b01; a_addr = 16'h0100; a_wdata = 16'h55AA; a_req2 = 1'b1;
    ack_cyc = 0; w0c = 0; w1c = 0; rdc = 0; doen_ok = 0; aoen_ok = 0; bown_c = 0; oth_c = 0; acks = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (!wrn0_2) w0c++;
      if (!wrn1_2) w1c++;
      if (!rdn2)   rdc++;
      if (!doen2 && dout2 == 16'h55AA) doen_ok++;
      if (!aoen2 && addr2 == 16'h0100) aoen_ok++;
      if (b_owner2) bown_c++;
      if (b_ack2) oth_c++;
      if (a_ack2) begin acks++; if (ack_cyc == 0) ack_cyc = k; a_req2 = 1'b0; end
      if (k == 2) begin a_addr = 16'hDEAD; a_wdata = 16'h0BAD; end
    end
    check("ws2_ack_cyc", ack_cyc, 5);
    check("ws2_ack_pulses", acks, 1);
    check("ws2_wrn0_low", w0c, 3);
    check("ws2_wrn1_low", w1c, 0);
    check("ws2_rdn_low", rdc, 0);
    check("ws2_dbus_oen_dout", doen_ok, 5);
    check("ws2_abus_oen_addr", aoen_ok, 5);
    check("ws2_b_side", bown_c + oth_c, 0);

    // Back-to-back A reads
    a_wr = 1'b0; a_addr = 16'h0010; din = 16'h1111; a_req = 1'b1;
    seen_low = 0; high_run = 0; gap = 0; rd_low = 0; n_ack = 0; ack1 = 0; ack2 = 0;
    rd1 = 0; rd2 = 0; saddr1 = 0; saddr2 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (!rdn0) begin
        if (seen_low && high_run > 0) gap = high_run;
        rd_low++;
        if (rd_low == 1) saddr1 = addr0; else saddr2 = addr0;
        high_run = 0;
        seen_low = 1;
      end else if (seen_low) begin
        high_run++;
      end
      if (a_ack0) begin
        n_ack++;
        if (n_ack == 1) begin ack1 = k; rd1 = rdata0; a_addr = 16'h0011; din = 16'h2222; end
        else begin ack2 = k; rd2 = rdata0; a_req = 1'b0; end
      end
    end
    check("b2b_ack1_cyc", ack1, 3);
    check("b2b_ack2_cyc", ack2, 7);
    check("b2b_rdata1", rd1, 16'h1111);
    check("b2b_rdata2", rd2, 16'h2222);
    check("b2b_strobe_gap", gap, 3);
    check("b2b_strobe_count", rd_low, 2);
    check("b2b_addr1", saddr1, 16'h0010);
    check("b2b_addr2", saddr2, 16'h0011);

    // Reset in the middle of a two-wait-state read, request still pending afterwards
    a_wr = 1'b0; a_addr = 16'h0777; din = 16'h9999; a_req2 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    check("rstmid_rdn_before", rdn2, 1'b0);
    RESETN = 1'b0;
    #1;
    check("rstmid_strobes_async", {rdn2, wrn0_2, wrn1_2, aoen2, doen2}, 5'b11111);
    acks = 0;
    repeat (2) begin
      @(posedge CLK); @(negedge CLK);
      if (a_ack2) acks++;
    end
    check("rstmid_no_ack", acks, 0);
    check("rstmid_rdata_cleared", rdata2, 16'h0000);
    RESETN = 1'b1;
    ack_cyc = 0; rdc = 0; aoen_first = 0; cap_rdata = 0; acks = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (!aoen2 && aoen_first == 0) aoen_first = k;
      if (!rdn2) rdc++;
      if (a_ack2) begin acks++; if (ack_cyc == 0) ack_cyc = k; cap_rdata = rdata2; a_req2 = 1'b0; end
    end
    check("rstmid_restart_setup", aoen_first, 1);
    check("rstmid_rdn_low", rdc, 3);
    check("rstmid_ack_cyc", ack_cyc, 5);
    check("rstmid_ack_pulses", acks, 1);
    check("rstmid_rdata", cap_rdata, 16'h9999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
